sll: RTL and testbench

SLL -- requirements
Module: sll

---
 rtl/sll.sv | 78 +++++++
 tb/tb_sll.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sll.sv
// sll: 32-bit logical left shifter, one-cycle latency, one result per clock.
// The shift itself is a five-stage logarithmic mux network built from
// combinational logic. Only the output stage (rd, out_valid, optional zero)
// is registered.
// Optional feature macro: SLL_ZERO_FLAG_EN -- adds a registered 'zero' port
// that is high when the registered result is all zeros.
module sll (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   input  logic [31:0] rt,
   input  logic [4:0]  shamt,
`ifdef SLL_ZERO_FLAG_EN
   output logic        zero,
`endif
   output logic        out_valid,
   output logic [31:0] rd
);

   // Stage 0 is the raw operand. Stage k+1 is stage k, shifted by 2^k
   // when shamt[k] is set.
   logic [31:0] w_stage [0:5];
   logic [31:0] w_result;

   logic [31:0] r_rd;
   logic        r_out_valid;

   assign w_stage[0] = rt;

   genvar gi;
   generate
      for (gi = 0; gi < 5; gi = gi + 1) begin : g_shift_stage
         localparam int SH = 1 << gi;
         logic [31:0] w_shifted;
         // Vacated LSBs fill with zero. Bits pushed past bit 31 are dropped.
         assign w_shifted = {w_stage[gi][31-SH:0], {SH{1'b0}}};
         assign w_stage[gi+1] = shamt[gi] ? w_shifted : w_stage[gi];
      end
   endgenerate

   assign w_result = w_stage[5];

   // Output register. rd only loads on valid samples, so X/Z on the data
   // inputs while in_valid is low cannot disturb it.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_rd        <= 32'h0000_0000;
         r_out_valid <= 1'b0;
      end else begin
         r_out_valid <= in_valid;
         if (in_valid) begin
            r_rd <= w_result;
         end
      end
   end

   assign rd        = r_rd;
   assign out_valid = r_out_valid;

`ifdef SLL_ZERO_FLAG_EN
   logic r_zero;
   logic w_result_zero;

   assign w_result_zero = (w_result == 32'h0000_0000);

   // Zero flag tracks rd. Reset clears rd, so the flag reads 1 during reset.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_zero <= 1'b1;
      end else if (in_valid) begin
         r_zero <= w_result_zero;
      end
   end

   assign zero = r_zero;
`endif

endmodule

// File: tb/tb_sll.sv
// tb_sll: directed self-checking bench for sll. Each scenario task drives
// stimulus and checks against hand-computed expected values.
module tb_sll;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic [31:0] rt;
   logic [4:0]  shamt;
   logic        out_valid;
   logic [31:0] rd;
`ifdef SLL_ZERO_FLAG_EN
   logic        zero;
`endif

   int total;
   int bad;

   logic [31:0] vec_rt  [0:11];
   logic [4:0]  vec_sh  [0:11];
   logic [31:0] vec_exp [0:11];

   sll dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .rt        (rt),
      .shamt     (shamt),
`ifdef SLL_ZERO_FLAG_EN
      .zero      (zero),
`endif
      .out_valid (out_valid),
      .rd        (rd)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Present one sample on the falling edge, so it is stable for the next rising edge.
   task automatic drive(input logic v, input logic [31:0] a, input logic [4:0] s);
      @(negedge clk);
      in_valid = v;
      rt       = a;
      shamt    = s;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      in_valid = 1'b0;
      rt = 32'h0;
      shamt = 5'd0;
      #1;
      total++;
      if (rd !== 32'h0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_initial: rd=%h out_valid=%b expected rd=00000000 out_valid=0", rd, out_valid);
      end
`ifdef SLL_ZERO_FLAG_EN
      total++;
      if (zero !== 1'b1) begin
         bad++;
         $display("FAIL reset_zero: zero=%b expected 1", zero);
      end
`endif
      // A valid sample held during reset must not be captured.
      drive(1'b1, 32'hFFFF_FFFF, 5'd1);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL reset_held: rd=%h out_valid=%b expected rd=00000000 out_valid=0", rd, out_valid);
      end
      $display("reset: rd=%h out_valid=%b", rd, out_valid);
      @(negedge clk);
      in_valid = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_shift_vectors();
      vec_rt  = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1234_5678,
                  32'h0000_0001, 32'h0000_0003, 32'h0000_0001, 32'h0000_0007,
                  32'h0000_FFFF, 32'hDEAD_BEEE, 32'h7FFF_FFFF, 32'hA5A5_A5A5};
      vec_sh  = '{5'd1, 5'd3, 5'd31, 5'd0,
                  5'd16, 5'd5, 5'd10, 5'd21,
                  5'd8, 5'd31, 5'd2, 5'd4};
      vec_exp = '{32'hFFFF_FFFE, 32'hFFFF_FFF8, 32'h8000_0000, 32'h1234_5678,
                  32'h0001_0000, 32'h0000_0060, 32'h0000_0400, 32'h00E0_0000,
                  32'h00FF_FF00, 32'h0000_0000, 32'hFFFF_FFFC, 32'h5A5A_5A50};
      for (int i = 0; i < 12; i++) begin
         drive(1'b1, vec_rt[i], vec_sh[i]);
         @(posedge clk); #1;
         total++;
         if (rd !== vec_exp[i] || out_valid !== 1'b1) begin
            bad++;
            $display("FAIL shift_vec%0d: rd=%h out_valid=%b expected rd=%h out_valid=1",
                     i, rd, out_valid, vec_exp[i]);
         end
         $display("shift: rt=%h shamt=%0d rd=%h out_valid=%b", vec_rt[i], vec_sh[i], rd, out_valid);
         // Idle cycle: the result must hold and the valid pulse must drop.
         drive(1'b0, vec_rt[i], vec_sh[i]);
         @(posedge clk); #1;
         total++;
         if (rd !== vec_exp[i] || out_valid !== 1'b0) begin
            bad++;
            $display("FAIL idle_vec%0d: rd=%h out_valid=%b expected rd=%h out_valid=0",
                     i, rd, out_valid, vec_exp[i]);
         end
      end
   endtask

   task automatic test_back_to_back();
      drive(1'b1, 32'h0000_0001, 5'd1);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0000_0002 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_first: rd=%h out_valid=%b expected rd=00000002 out_valid=1", rd, out_valid);
      end
      $display("b2b: rd=%h out_valid=%b", rd, out_valid);
      drive(1'b1, 32'h0000_0003, 5'd2);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0000_000C || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_second: rd=%h out_valid=%b expected rd=0000000c out_valid=1", rd, out_valid);
      end
      $display("b2b: rd=%h out_valid=%b", rd, out_valid);
      drive(1'b1, 32'hF0F0_F0F0, 5'd12);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0F0F_0000 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL b2b_third: rd=%h out_valid=%b expected rd=0f0f0000 out_valid=1", rd, out_valid);
      end
      $display("b2b: rd=%h out_valid=%b", rd, out_valid);
      drive(1'b0, 32'h0000_0000, 5'd0);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0F0F_0000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL b2b_hold: rd=%h out_valid=%b expected rd=0f0f0000 out_valid=0", rd, out_valid);
      end
      $display("b2b idle: rd=%h out_valid=%b", rd, out_valid);
   endtask

   task automatic test_hold_xz();
      drive(1'b0, 32'hxxxx_zzzz, 5'bx0z1x);
      @(posedge clk); #1;
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0F0F_0000 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL hold_xz: rd=%h out_valid=%b expected rd=0f0f0000 out_valid=0", rd, out_valid);
      end
      $display("hold xz: rd=%h out_valid=%b", rd, out_valid);
   endtask

   task automatic test_reset_midstream();
      drive(1'b1, 32'h0000_0001, 5'd4);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0000_0010 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_pre: rd=%h out_valid=%b expected rd=00000010 out_valid=1", rd, out_valid);
      end
      // A new sample is in flight. Reset arrives between clock edges.
      drive(1'b1, 32'h0000_FFFF, 5'd4);
      #2;
      rst = 1'b1;
      #1;
      total++;
      if (rd !== 32'h0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_async: rd=%h out_valid=%b expected rd=00000000 out_valid=0", rd, out_valid);
      end
`ifdef SLL_ZERO_FLAG_EN
      total++;
      if (zero !== 1'b1) begin
         bad++;
         $display("FAIL mid_zero: zero=%b expected 1", zero);
      end
`endif
      $display("mid reset: rd=%h out_valid=%b", rd, out_valid);
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      in_valid = 1'b0;
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0 || out_valid !== 1'b0) begin
         bad++;
         $display("FAIL mid_lost: rd=%h out_valid=%b expected rd=00000000 out_valid=0", rd, out_valid);
      end
      // The first edge after release captures normally.
      drive(1'b1, 32'h0000_00FF, 5'd8);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0000_FF00 || out_valid !== 1'b1) begin
         bad++;
         $display("FAIL mid_recover: rd=%h out_valid=%b expected rd=0000ff00 out_valid=1", rd, out_valid);
      end
      $display("post reset: rd=%h out_valid=%b", rd, out_valid);
      drive(1'b0, 32'h0, 5'd0);
   endtask

`ifdef SLL_ZERO_FLAG_EN
   task automatic test_zero_flag();
      drive(1'b1, 32'h0000_0001, 5'd31);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h8000_0000 || zero !== 1'b0) begin
         bad++;
         $display("FAIL zero_clear: rd=%h zero=%b expected rd=80000000 zero=0", rd, zero);
      end
      $display("zero: rd=%h zero=%b", rd, zero);
      drive(1'b1, 32'h8000_0000, 5'd1);
      @(posedge clk); #1;
      total++;
      if (rd !== 32'h0 || zero !== 1'b1) begin
         bad++;
         $display("FAIL zero_set: rd=%h zero=%b expected rd=00000000 zero=1", rd, zero);
      end
      $display("zero: rd=%h zero=%b", rd, zero);
      drive(1'b0, 32'h0000_0001, 5'd0);
      @(posedge clk); #1;
      total++;
      if (zero !== 1'b1) begin
         bad++;
         $display("FAIL zero_hold: zero=%b expected 1", zero);
      end
   endtask
`endif

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_shift_vectors();
      test_back_to_back();
      test_hold_xz();
      test_reset_midstream();
`ifdef SLL_ZERO_FLAG_EN
      test_zero_flag();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
